shift_pattern_sequencer: RTL and testbench
==========================================

// Module: shift_pattern_sequencer
// PURPOSE
//  Command-driven sequencer for an 8-bit logical barrel shifter: captures a pattern, steps shift amount/direction
//  on a prescaled tick and presents the shifted result. Runs a bounded or free-running number of steps, with a
//  start/busy/done handshake. Sits between a control FSM/switch front-end and the LED output.
// PARAMETERS
//  WIDTH     8            data width; power of 2; AMT_W = $clog2(WIDTH) (localparam)
//  TICK_DIV  100_000_000  clk cycles per step (1 Hz at 100 MHz); >= 2
//  STEP_W    8            width of num_steps and the internal step counter
// PORTS
//  clk        in   1       system clock; single clock domain
//  reset      in   1       synchronous, active-high reset
//  start      in   1       1-cycle request; accepted only in IDLE
//  mode       in   2       00 left sweep, 01 right sweep, 10 ping-pong (macro), 11 = left sweep
//  num_steps  in   STEP_W  steps to run; 0 = free-run until stop; sampled at start
//  stop       in   1       abort request; honoured only in RUN
//  dat_in     in   WIDTH   pattern; sampled at start
//  dat_out    out  WIDTH   registered shifted pattern
//  amt        out  AMT_W   current shift amount
//  dir        out  1       0 = left, 1 = right
//  busy       out  1       high in RUN
//  done       out  1       1-cycle pulse on completion/abort
// BEHAVIOUR
//  - Reset (sync): state=IDLE; amt=0, dir=0, dat_out=0, busy=0, done=0; prescaler and step counter = 0.
//  - FSM IDLE -> RUN on start; RUN -> FINISH on last step or stop; FINISH -> IDLE unconditionally (1 cycle).
//  - On accepted start: capture dat_in, mode, num_steps; amt=0; dir=(mode==01); prescaler and step count cleared;
//    busy=1 from the next cycle.
//  - Tick: 1-cycle internal enable when prescaler reaches TICK_DIV-1, then wraps to 0. First step lands
//    TICK_DIV cycles after start. No derived or gated clocks; all flops on clk.
//  - Each tick in RUN: amt <= amt+1, wrapping WIDTH-1 -> 0; step counter +1 (wraps in free-run).
//  - dat_out = dir ? pattern >> amt : pattern << amt, zero fill; registered one cycle after the amt/dir update.
//  - Bounded run: the tick where step count == num_steps-1 executes the step, then goes to FINISH.
//  - stop in RUN -> FINISH next cycle; a pending tick in that same cycle is still executed.
//  - stop coincident with the final tick -> exactly one FINISH and one done.
//  - In FINISH: done=1, busy=0; amt/dir/dat_out hold the last values until the next start.
//  - start while busy or in FINISH is ignored (not queued). stop in IDLE is ignored.
//    start+stop together in IDLE -> start wins.
//  - reset mid-run: full abort to reset values on the next edge; no done pulse.
// CONFIGURATION
//  - `SHIFT_SEQ_PINGPONG_EN defined: mode 10 = ping-pong. Starts dir=0; on each amt wrap WIDTH-1 -> 0, dir toggles.
//  - Not defined: mode 10 behaves as left sweep; dir stays constant for the whole run. No ping-pong logic synthesised.
// STRUCTURE
//  - Package shift_seq_pkg holds:
//      typedef enum logic [1:0] {MODE_LEFT, MODE_RIGHT, MODE_PINGPONG, MODE_RSVD} shift_mode_t;
//      typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} seq_state_t;
//  - Sub-module tick_gen #(TICK_DIV): mod-TICK_DIV counter with clr input and tick output.
//  - Top holds the FSM, step/amt/dir registers and the shift datapath.
// TESTING (TICK_DIV=4 unless noted)
//  1. reset high 2 cycles mid-activity -> next cycle dat_out=0, amt=0, dir=0, busy=0, done=0.
//  2. start, mode=00, num_steps=3, dat_in=8'h81 -> amt 1,2,3 at +4/+8/+12 cycles;
//     dat_out 8'h02, 8'h04, 8'h08; single done pulse; amt holds 3.
//  3. mode=01, num_steps=9, dat_in=8'h80 -> step 7: amt=7, dat_out=8'h01;
//     step 8: amt=0, dat_out=8'h80; done after step 9.
//  4. num_steps=0, stop asserted 1 cycle after the 5th tick -> amt=5, done pulses once, busy=0; no further steps.
//  5. start pulsed while busy -> ignored; stop on the same cycle as the final tick -> exactly one done.
//  6. With SHIFT_SEQ_PINGPONG_EN: mode=10, num_steps=10 -> dir=1 and amt=0 at step 8;
//     without the macro -> dir stays 0.

Source files
------------

// File: rtl/shift_pattern_sequencer_pkg.sv
// Shared types for the shift pattern sequencer: shift modes, FSM states and small helpers.
package shift_seq_pkg;

  typedef enum logic [1:0] {MODE_LEFT, MODE_RIGHT, MODE_PINGPONG, MODE_RSVD} shift_mode_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} seq_state_t;

  // Only an explicit right sweep starts shifting right; ping-pong starts left.
  function automatic logic mode_dir(shift_mode_t m);
    return m == MODE_RIGHT;
  endfunction

endpackage

// File: rtl/shift_pattern_sequencer_if.sv
// Command/result bundle between the control front-end (master) and the sequencer (slave).
interface shift_pattern_sequencer_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
);
  localparam int AMT_W = $clog2(WIDTH);

  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [STEP_W-1:0] num_steps;
  logic [WIDTH-1:0]  dat_in;
  logic [WIDTH-1:0]  dat_out;
  logic [AMT_W-1:0]  amt;
  logic              dir;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, mode, num_steps, dat_in,
    input  dat_out, amt, dir, busy, done
  );

  modport slave (
    input  start, stop, mode, num_steps, dat_in,
    output dat_out, amt, dir, busy, done
  );

endinterface

// File: rtl/shift_pattern_sequencer_tick_gen.sv
// Prescaler: mod-TICK_DIV counter producing a one-cycle tick on its last count.
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shift_pattern_sequencer.sv
// Command-driven barrel-shift sequencer: steps amt/dir on a prescaled tick, bounded or free-running.
// Optional feature macro: SHIFT_SEQ_PINGPONG_EN (mode 10 reverses direction on every amt wrap).
module shift_pattern_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 100_000_000,
  parameter int STEP_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  shift_pattern_sequencer_if.slave  bus
);
  localparam int AMT_W = $clog2(WIDTH);

  seq_state_t        state_q, state_d;
  logic [WIDTH-1:0]  pat_q;
  logic [WIDTH-1:0]  dat_q, dat_d;
  logic [STEP_W-1:0] nsteps_q;
  logic [STEP_W-1:0] step_q, step_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic              dir_q, dir_d;
  logic              tick_raw, tick, start_acc, last_step;

  // Prescaler is held clear outside RUN so the first step lands TICK_DIV cycles after start.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q != S_RUN),
    .tick_o (tick_raw)
  );

  assign start_acc = (state_q == S_IDLE) && bus.start;
  assign tick      = (state_q == S_RUN) && tick_raw;
  assign last_step = (nsteps_q != '0) && (step_q == nsteps_q - STEP_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_RUN;
      S_RUN:    if (bus.stop || (tick && last_step)) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef SHIFT_SEQ_PINGPONG_EN
  logic pp_q;
  always_ff @(posedge clk) begin
    if (reset)          pp_q <= 1'b0;
    else if (start_acc) pp_q <= (shift_mode_t'(bus.mode) == MODE_PINGPONG);
  end
`endif

  always_comb begin
    amt_d  = amt_q;
    dir_d  = dir_q;
    step_d = step_q;
    if (start_acc) begin
      amt_d  = '0;
      dir_d  = mode_dir(shift_mode_t'(bus.mode));
      step_d = '0;
    end else if (tick) begin
      // WIDTH is a power of two, so amt wraps WIDTH-1 -> 0 on its own.
      amt_d  = amt_q + AMT_W'(1);
      step_d = step_q + STEP_W'(1);
`ifdef SHIFT_SEQ_PINGPONG_EN
      if (pp_q && (amt_q == AMT_W'(WIDTH - 1))) dir_d = ~dir_q;
`endif
    end
  end

  always_comb begin
    dat_d = dir_q ? (pat_q >> amt_q) : (pat_q << amt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      nsteps_q <= '0;
      step_q   <= '0;
      amt_q    <= '0;
      dir_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      amt_q   <= amt_d;
      dir_q   <= dir_d;
      dat_q   <= dat_d;
      if (start_acc) begin
        pat_q    <= bus.dat_in;
        nsteps_q <= bus.num_steps;
      end
    end
  end

  assign bus.dat_out = dat_q;
  assign bus.amt     = amt_q;
  assign bus.dir     = dir_q;
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_FINISH);

endmodule

// File: tb/tb_shift_pattern_sequencer.sv
// Self-checking bench for shift_pattern_sequencer (TICK_DIV=4) against a step-indexed reference model.
module tb_shift_pattern_sequencer;
  localparam int W  = 8;
  localparam int TD = 4;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_pattern_sequencer_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  shift_pattern_sequencer #(.WIDTH(W), .TICK_DIV(TD), .STEP_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Direction after k steps of a run started in the given mode.
  function automatic logic ref_dir(input int mode, input int k);
    if (mode == 1) return 1'b1;
`ifdef SHIFT_SEQ_PINGPONG_EN
    if (mode == 2) return ((k / W) % 2) == 1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] ref_dat(input logic [W-1:0] p, input int mode, input int k);
    logic [W-1:0] r;
    int a;
    a = k % W;
    if (ref_dir(mode, k)) r = p >> a;
    else                  r = p << a;
    return r;
  endfunction

  // One run: stop_k>0 raises stop one cycle after tick stop_k; coincide raises stop on the final tick.
  task automatic run(input int mode, input int n, input logic [W-1:0] pat, input int stop_k,
                     input bit coincide, input bit sws, input string tg);
    bit fin;
    fin = 1'b0;
    bus.mode = mode[1:0]; bus.num_steps = n[SW-1:0]; bus.dat_in = pat;
    bus.start = 1'b1; bus.stop = sws;
    cyc();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk({tg, ":busy_start"}, bus.busy, 1);
    chk({tg, ":amt_start"}, bus.amt, 0);
    for (int k = 1; k <= 300 && !fin; k++) begin
      cyc();
      chk({tg, ":dat"}, bus.dat_out, ref_dat(pat, mode, k - 1));
      if (k == 1) begin
        bus.start = 1'b1; bus.dat_in = ~pat; bus.num_steps = 8'd1; bus.mode = 2'b01;
      end
      cyc();
      bus.start = 1'b0; bus.dat_in = pat; bus.num_steps = n[SW-1:0]; bus.mode = mode[1:0];
      cyc();
      if (coincide && k == n) bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      chk({tg, ":amt"}, bus.amt, k % W);
      chk({tg, ":dir"}, bus.dir, ref_dir(mode, k));
      if (n != 0 && k == n) begin
        chk({tg, ":done_end"}, bus.done, 1);
        chk({tg, ":busy_end"}, bus.busy, 0);
        cyc();
        chk({tg, ":dat_end"}, bus.dat_out, ref_dat(pat, mode, k));
        for (int j = 0; j < 3; j++) begin
          chk({tg, ":done_once"}, bus.done, 0);
          chk({tg, ":amt_hold"}, bus.amt, k % W);
          cyc();
        end
        fin = 1'b1;
      end else begin
        chk({tg, ":done_mid"}, bus.done, 0);
        chk({tg, ":busy_mid"}, bus.busy, 1);
        if (k == stop_k) begin
          bus.stop = 1'b1;
          cyc();
          bus.stop = 1'b0;
          chk({tg, ":done_stop"}, bus.done, 1);
          chk({tg, ":busy_stop"}, bus.busy, 0);
          chk({tg, ":amt_stop"}, bus.amt, k % W);
          chk({tg, ":dat_stop"}, bus.dat_out, ref_dat(pat, mode, k));
          cyc();
          chk({tg, ":done_once"}, bus.done, 0);
          repeat (2 * TD) cyc();
          chk({tg, ":amt_frozen"}, bus.amt, k % W);
          chk({tg, ":busy_idle"}, bus.busy, 0);
          chk({tg, ":done_idle"}, bus.done, 0);
          fin = 1'b1;
        end
      end
    end
    chk({tg, ":finished"}, fin, 1);
    cyc();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, n, sk;
    bit co;
    logic [W-1:0] p;

    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00; bus.num_steps = '0; bus.dat_in = '0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst:dat", bus.dat_out, 0);
    chk("rst:amt", bus.amt, 0);
    chk("rst:dir", bus.dir, 0);
    chk("rst:busy", bus.busy, 0);
    chk("rst:done", bus.done, 0);

    // stop while idle has no effect
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("idle_stop:busy", bus.busy, 0);
    chk("idle_stop:done", bus.done, 0);

    run(0, 3, 8'h81, 0, 1'b0, 1'b1, "left3");
    run(1, 9, 8'h80, 0, 1'b0, 1'b0, "right9");
    run(0, 0, 8'h81, 5, 1'b0, 1'b0, "free_stop5");
    run(0, 4, 8'h3c, 0, 1'b1, 1'b0, "stop_on_last");
    run(2, 10, 8'h81, 0, 1'b0, 1'b0, "mode2_10");
    run(3, 2, 8'hff, 0, 1'b0, 1'b0, "mode3_2");

    for (int i = 0; i < 8; i++) begin
      m  = $urandom_range(0, 3);
      n  = $urandom_range(0, 12);
      p  = W'($urandom);
      co = 1'b0;
      sk = 0;
      if (n == 0) sk = $urandom_range(1, 12);
      else if ($urandom_range(0, 2) == 0) co = 1'b1;
      else if (n > 1 && $urandom_range(0, 2) == 0) sk = $urandom_range(1, n - 1);
      run(m, n, p, sk, co, 1'b0, "rand");
    end

    // reset in the middle of a run
    bus.mode = 2'b01; bus.num_steps = 8'd20; bus.dat_in = 8'ha5; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (6) cyc();
    reset = 1'b1;
    cyc();
    chk("midrst:dat", bus.dat_out, 0);
    chk("midrst:amt", bus.amt, 0);
    chk("midrst:dir", bus.dir, 0);
    chk("midrst:busy", bus.busy, 0);
    chk("midrst:done", bus.done, 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("postrst:dat", bus.dat_out, 0);
    chk("postrst:amt", bus.amt, 0);
    chk("postrst:busy", bus.busy, 0);
    for (int j = 0; j < 2 * TD; j++) begin
      chk("postrst:done", bus.done, 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
